// File: rtl/flow_ctrl_fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : flow_ctrl_fsm_param
// Description : Flow-control FSM for N_CH egress FIFOs plus one ingress FIFO.
//               Per-channel pause with hysteresis, sticky error capture and
//               saturating per-FIFO overflow counters.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_ctrl_fsm_param #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 4,
    parameter int PAUSE_ON_FULL = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic                        iniciar,
    input  logic                        clr_error,
    input  logic [N_CH:0]               almost_full,
    input  logic [N_CH:0]               full,
    input  logic [N_CH:0]               almost_empty,
    input  logic [N_CH:0]               empty,
    output logic                        idle,
    output logic [N_CH-1:0]             pausa,
    output logic [N_CH-1:0]             continuar,
    output logic [N_CH:0]               error_full,
    output logic [(N_CH+1)*CNT_W-1:0]   err_count,
    output logic [2:0]                  state
);

    localparam int               c_NF      = N_CH + 1;
    localparam int               c_CW      = c_NF * CNT_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t            r_state_q,     w_state_d;
    logic              r_idle_q,      w_idle_d;
    logic [N_CH-1:0]   r_pause_q,     w_pause_d;
    logic [N_CH-1:0]   r_go_q,        w_go_d;
    logic [N_CH:0]     r_err_full_q,  w_err_full_d;
    logic [c_CW-1:0]   r_cnt_q,       w_cnt_d;

    logic              w_any_full;
    logic              w_all_empty;
    logic              w_enter_err;
    logic              w_stay_active;
    logic [N_CH-1:0]   w_trig;
    logic              w_unused_flags;

    assign w_any_full  = |full;
    assign w_all_empty = &empty;

    // The ingress almost flags never influence pausing; almost_full is
    // entirely unused when pausing is keyed on the full flags.
    assign w_unused_flags = ^{almost_full, almost_empty[N_CH]};

    generate
        if (PAUSE_ON_FULL != 0) begin : g_trig_full
            assign w_trig = full[N_CH-1:0];
        end else begin : g_trig_afull
            assign w_trig = almost_full[N_CH-1:0];
        end
    endgenerate

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_RESET:  w_state_d = ST_INIT;
            ST_INIT:   if (iniciar) w_state_d = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: begin
                if (w_any_full)       w_state_d = ST_ERROR;
                else if (w_all_empty) w_state_d = ST_IDLE;
                else                  w_state_d = ST_ACTIVE;
            end
            ST_ERROR:  if (clr_error && !w_any_full) w_state_d = ST_IDLE;
            default:   w_state_d = ST_RESET;
        endcase
    end

    assign w_enter_err   = ((r_state_q == ST_IDLE) || (r_state_q == ST_ACTIVE)) && w_any_full;
    assign w_stay_active = (r_state_q == ST_ACTIVE) && (w_state_d == ST_ACTIVE);

    always_comb begin
        w_err_full_d = r_err_full_q;
        if (w_enter_err) begin
            w_err_full_d = full;
        end else if (r_state_q == ST_ERROR) begin
            w_err_full_d = (w_state_d == ST_ERROR) ? (r_err_full_q | full) : '0;
        end
    end

    // Set dominates clear; leaving ACTIVE (or entering it) starts from released.
    always_comb begin
        w_pause_d = '0;
        if (w_stay_active) begin
            w_pause_d = w_trig | (r_pause_q & ~almost_empty[N_CH-1:0]);
        end
        w_go_d   = (w_state_d == ST_ACTIVE) ? ~w_pause_d : '0;
        w_idle_d = (r_state_q == ST_IDLE) && w_all_empty;
    end

    generate
        for (genvar i = 0; i < c_NF; i++) begin : g_cnt
            logic [CNT_W-1:0] w_cur;
            assign w_cur = r_cnt_q[i*CNT_W +: CNT_W];
            assign w_cnt_d[i*CNT_W +: CNT_W] =
                (w_enter_err && full[i] && (w_cur != c_CNT_MAX)) ? (w_cur + c_CNT_ONE) : w_cur;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_RESET;
            r_idle_q     <= 1'b0;
            r_pause_q    <= '0;
            r_go_q       <= '0;
            r_err_full_q <= '0;
            r_cnt_q      <= '0;
        end else if (enb) begin
            r_state_q    <= w_state_d;
            r_idle_q     <= w_idle_d;
            r_pause_q    <= w_pause_d;
            r_go_q       <= w_go_d;
            r_err_full_q <= w_err_full_d;
            r_cnt_q      <= w_cnt_d;
        end
    end

    assign state      = r_state_q;
    assign idle       = r_idle_q;
    assign pausa      = r_pause_q;
    assign continuar  = r_go_q;
    assign error_full = r_err_full_q;
    assign err_count  = r_cnt_q;

endmodule
`default_nettype wire
